river_crossing_fsm: RTL and testbench

//  Sequential successor to the combinational farmer hazard checker: tracks farmer + N_ITEMS

---
 rtl/river_crossing_pkg.sv | 24 ++
 rtl/crossing_hazard.sv | 24 ++
 rtl/river_crossing_fsm.sv | 165 ++++++++++++++++
 tb/tb_river_crossing_fsm.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/river_crossing_pkg.sv
// Shared definitions for the river crossing game: state encoding, default predation
// matrix and item indices.
package river_crossing_pkg;

  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_LOST  = 2'd2;
  localparam logic [1:0] S_WON   = 2'd3;

  typedef enum logic [1:0] {
    StPlay  = S_PLAY,
    StCheck = S_CHECK,
    StLost  = S_LOST,
    StWon   = S_WON
  } state_e;

  // Bit i*3+j set means item i eats item j: fox eats goose, goose eats beans.
  localparam logic [8:0] EATS_DEFAULT = 9'h022;

  localparam int unsigned FOX   = 0;
  localparam int unsigned GOOSE = 1;
  localparam int unsigned BEANS = 2;

endpackage

// File: rtl/crossing_hazard.sv
// Combinational predation check: flags any predator/prey pair left together on the bank
// opposite the farmer.
module crossing_hazard #(
  parameter int unsigned                     N_ITEMS = 3,
  parameter logic [N_ITEMS*N_ITEMS-1:0]      EATS    = 9'h022
) (
  input  logic               farmer_side,
  input  logic [N_ITEMS-1:0] item_side,
  output logic               hazard
);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      for (int j = 0; j < N_ITEMS; j++) begin
        if ((i != j) && EATS[i*N_ITEMS+j] && (item_side[i] == item_side[j]) &&
            (farmer_side != item_side[i])) begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/river_crossing_fsm.sv
// River crossing game tracker: applies one move per handshake, then checks for a loss or win.
// Optional one-step undo is enabled by defining RIVER_CROSSING_UNDO_EN.
module river_crossing_fsm
  import river_crossing_pkg::*;
#(
  parameter int unsigned                N_ITEMS = 3,
  parameter logic [N_ITEMS*N_ITEMS-1:0] EATS    = EATS_DEFAULT,
  parameter int unsigned                CNT_W   = 8,
  parameter int unsigned                ITEM_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_valid,
  input  logic [ITEM_W-1:0]  move_item,
`ifdef RIVER_CROSSING_UNDO_EN
  input  logic               undo,
`endif
  output logic               move_ready,
  output logic               move_err,
  output logic               farmer_side,
  output logic [N_ITEMS-1:0] item_side,
  output logic               eaten,
  output logic               won,
  output logic [CNT_W-1:0]   move_count
);

  state_e             state_q, state_d;
  logic               farmer_q, farmer_d;
  logic [N_ITEMS-1:0] items_q, items_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               eaten_q, eaten_d;
  logic               won_q, won_d;
  logic [N_ITEMS-1:0] carry_mask;
  logic               legal;
  logic               hazard;

`ifdef RIVER_CROSSING_UNDO_EN
  logic               hist_valid_q, hist_valid_d;
  logic               hist_farmer_q, hist_farmer_d;
  logic [N_ITEMS-1:0] hist_items_q, hist_items_d;
  logic [CNT_W-1:0]   hist_count_q, hist_count_d;
`endif

  crossing_hazard #(
    .N_ITEMS(N_ITEMS),
    .EATS   (EATS)
  ) u_hazard (
    .farmer_side(farmer_q),
    .item_side  (items_q),
    .hazard     (hazard)
  );

  always_comb begin
    carry_mask = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (move_item == ITEM_W'(i)) carry_mask[i] = 1'b1;
    end
    // Out-of-range items decode to an empty mask and are rejected.
    legal = (move_item == ITEM_W'(N_ITEMS)) ||
            ((|carry_mask) && ((items_q & carry_mask) == ({N_ITEMS{farmer_q}} & carry_mask)));
  end

  always_comb begin
    state_d  = state_q;
    farmer_d = farmer_q;
    items_d  = items_q;
    count_d  = count_q;
    err_d    = 1'b0;
`ifdef RIVER_CROSSING_UNDO_EN
    hist_valid_d  = hist_valid_q;
    hist_farmer_d = hist_farmer_q;
    hist_items_d  = hist_items_q;
    hist_count_d  = hist_count_q;
`endif
    unique case (state_q)
      StPlay: begin
        if (move_valid) begin
          if (legal) begin
            farmer_d = ~farmer_q;
            items_d  = items_q ^ carry_mask;
            count_d  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
            state_d  = StCheck;
`ifdef RIVER_CROSSING_UNDO_EN
            hist_valid_d  = 1'b1;
            hist_farmer_d = farmer_q;
            hist_items_d  = items_q;
            hist_count_d  = count_q;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCheck: begin
        if (hazard) begin
          state_d = StLost;
        end else if (farmer_q && (&items_q)) begin
          state_d = StWon;
        end else begin
          state_d = StPlay;
        end
      end
      default: ;
    endcase
`ifdef RIVER_CROSSING_UNDO_EN
    // Undo overrides any move accepted in the same cycle.
    if (undo && hist_valid_q && ((state_q == StPlay) || (state_q == StLost))) begin
      farmer_d     = hist_farmer_q;
      items_d      = hist_items_q;
      count_d      = hist_count_q;
      err_d        = 1'b0;
      state_d      = StPlay;
      hist_valid_d = 1'b0;
    end
`endif
    ready_d = (state_d == StPlay);
    eaten_d = (state_d == StLost);
    won_d   = (state_d == StWon);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StPlay;
      farmer_q <= 1'b0;
      items_q  <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      eaten_q  <= 1'b0;
      won_q    <= 1'b0;
`ifdef RIVER_CROSSING_UNDO_EN
      hist_valid_q  <= 1'b0;
      hist_farmer_q <= 1'b0;
      hist_items_q  <= '0;
      hist_count_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      farmer_q <= farmer_d;
      items_q  <= items_d;
      count_q  <= count_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      eaten_q  <= eaten_d;
      won_q    <= won_d;
`ifdef RIVER_CROSSING_UNDO_EN
      hist_valid_q  <= hist_valid_d;
      hist_farmer_q <= hist_farmer_d;
      hist_items_q  <= hist_items_d;
      hist_count_q  <= hist_count_d;
`endif
    end
  end

  assign move_ready  = ready_q;
  assign move_err    = err_q;
  assign farmer_side = farmer_q;
  assign item_side   = items_q;
  assign eaten       = eaten_q;
  assign won         = won_q;
  assign move_count  = count_q;

endmodule

// File: tb/tb_river_crossing_fsm.sv
// Bench for river_crossing_fsm: table-driven moves with a scoreboard queue, plus hand-written
// corner sequences. A second instance with a 2-bit counter checks saturation.
module tb_river_crossing_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       move_valid;
  logic [1:0] move_item;
  logic       undo;

  logic       move_ready, move_err, farmer_side, eaten, won;
  logic [2:0] item_side;
  logic [7:0] move_count;

  logic       s_ready, s_err, s_farmer, s_eaten, s_won;
  logic [2:0] s_items;
  logic [1:0] s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  river_crossing_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .move_valid (move_valid),
    .move_item  (move_item),
`ifdef RIVER_CROSSING_UNDO_EN
    .undo       (undo),
`endif
    .move_ready (move_ready),
    .move_err   (move_err),
    .farmer_side(farmer_side),
    .item_side  (item_side),
    .eaten      (eaten),
    .won        (won),
    .move_count (move_count)
  );

  river_crossing_fsm #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .move_valid (move_valid),
    .move_item  (move_item),
`ifdef RIVER_CROSSING_UNDO_EN
    .undo       (undo),
`endif
    .move_ready (s_ready),
    .move_err   (s_err),
    .farmer_side(s_farmer),
    .item_side  (s_items),
    .eaten      (s_eaten),
    .won        (s_won),
    .move_count (s_count)
  );

  typedef struct {
    bit         rst;
    logic [1:0] item;
    bit         err;
    bit         eaten;
    bit         won;
    bit         ready;
    logic [7:0] cnt;
    logic [1:0] sat;
    bit         farmer;
    logic [2:0] items;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    move_valid = 1'b0;
    undo       = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int tag);
    vec_t e;
    bit   ok;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (move_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check($sformatf("ready_timeout[%0d]", tag), 32'(move_ready), 32'd1);
      return;
    end
    move_valid = 1'b1;
    move_item  = v.item;
    sb.push_back(v);
    @(posedge clk);
    #1 move_valid = 1'b0;
    e = sb.pop_front();
    // Legal moves spend one cycle in CHECK before the outcome is visible.
    if (!e.err) @(posedge clk);
    @(negedge clk);
    check($sformatf("err[%0d]", tag), 32'(move_err), 32'(e.err));
    check($sformatf("eaten[%0d]", tag), 32'(eaten), 32'(e.eaten));
    check($sformatf("won[%0d]", tag), 32'(won), 32'(e.won));
    check($sformatf("ready[%0d]", tag), 32'(move_ready), 32'(e.ready));
    check($sformatf("count[%0d]", tag), 32'(move_count), 32'(e.cnt));
    check($sformatf("sat_count[%0d]", tag), 32'(s_count), 32'(e.sat));
    check($sformatf("farmer[%0d]", tag), 32'(farmer_side), 32'(e.farmer));
    check($sformatf("items[%0d]", tag), 32'(item_side), 32'(e.items));
  endtask

  initial begin
    vec_t v;
    // rst, item, err, eaten, won, ready, cnt, sat, farmer, items
    vecs[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1, 1'b1, 3'b010};
    vecs[1]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 2'd2, 1'b0, 3'b010};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 2'd3, 1'b1, 3'b011};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 2'd3, 1'b0, 3'b001};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 2'd3, 1'b1, 3'b101};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 2'd3, 1'b0, 3'b101};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7, 2'd3, 1'b1, 3'b111};
    vecs[7]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1, 1'b1, 3'b000};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1, 1'b1, 3'b010};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1, 1'b1, 3'b010};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1, 1'b1, 3'b010};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 2'd2, 1'b0, 3'b010};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 2'd3, 1'b1, 3'b010};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 2'd3, 1'b0, 3'b010};
    vecs[14] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 2'd3, 1'b1, 3'b010};

    move_valid = 1'b0;
    move_item  = 2'd0;
    undo       = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(move_ready), 32'd1);
    check("rst_err", 32'(move_err), 32'd0);
    check("rst_eaten", 32'(eaten), 32'd0);
    check("rst_won", 32'(won), 32'd0);
    check("rst_count", 32'(move_count), 32'd0);
    check("rst_sides", 32'({farmer_side, item_side}), 32'd0);

    for (int k = 0; k < NV; k++) begin
      if (vecs[k].rst) do_reset();
      apply_vec(vecs[k], k);
    end

    // Moves offered while LOST are ignored.
    do_reset();
    apply_vec(vecs[7], 100);
    move_valid = 1'b1;
    move_item  = 2'd1;
    repeat (3) @(posedge clk);
    #1 move_valid = 1'b0;
    @(negedge clk);
    check("lost_hold_eaten", 32'(eaten), 32'd1);
    check("lost_hold_ready", 32'(move_ready), 32'd0);
    check("lost_hold_count", 32'(move_count), 32'd1);
    check("lost_hold_err", 32'(move_err), 32'd0);

    // move_err is a single-cycle pulse.
    do_reset();
    apply_vec(vecs[8], 101);
    apply_vec(vecs[9], 102);
    @(posedge clk);
    @(negedge clk);
    check("err_pulse_end", 32'(move_err), 32'd0);
    check("err_pulse_ready", 32'(move_ready), 32'd1);

    // Reset asserted while in CHECK.
    do_reset();
    @(negedge clk);
    move_valid = 1'b1;
    move_item  = 2'd1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    check("check_state_ready", 32'(move_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_check_ready", 32'(move_ready), 32'd1);
    check("rst_in_check_count", 32'(move_count), 32'd0);
    check("rst_in_check_sides", 32'({farmer_side, item_side}), 32'd0);
    check("rst_in_check_eaten", 32'(eaten), 32'd0);

`ifdef RIVER_CROSSING_UNDO_EN
    do_reset();
    v = vecs[7];
    apply_vec(v, 103);
    for (int u = 0; u < 2; u++) begin
      undo = 1'b1;
      @(posedge clk);
      #1 undo = 1'b0;
      @(negedge clk);
      check($sformatf("undo_eaten[%0d]", u), 32'(eaten), 32'd0);
      check($sformatf("undo_ready[%0d]", u), 32'(move_ready), 32'd1);
      check($sformatf("undo_count[%0d]", u), 32'(move_count), 32'd0);
      check($sformatf("undo_sides[%0d]", u), 32'({farmer_side, item_side}), 32'd0);
    end
`else
    v = vecs[0];
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
